truth_table_sequencer: RTL and testbench

//   Self-timed stimulus/capture stage for 4-input combinational units under test.

---
 rtl/truth_table_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_truth_table_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Sweeps {A,B,C,D} through all 16 vectors, holding each for DWELL cycles, and captures F into tt.
// Optional golden-table comparison (mismatch, err_cnt) is enabled by defining TT_CHECK_EN.
module truth_table_sequencer #(
  parameter int unsigned DWELL    = 8,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt
`ifdef TT_CHECK_EN
  ,
  output logic        mismatch,
  output logic [4:0]  err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  if (DWELL < 2 || DWELL > 255 || $bits(EXPECTED) != 16) begin : g_bad_param
    $error("truth_table_sequencer: DWELL must be in 2..255");
  end

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  idx_r;
  logic [3:0]  idx_next_s;
  logic [7:0]  cnt_r;
  logic [7:0]  cnt_next_s;
  logic [15:0] tt_r;
  logic [15:0] tt_next_s;
  logic [3:0]  vec_r;
  logic [3:0]  vec_next_s;
  logic        busy_r;
  logic        busy_next_s;
  logic        done_r;
  logic        done_next_s;
  logic        last_s;
  logic        accept_s;
  logic        sweep_end_s;

  assign last_s      = (cnt_r == CNT_LAST);
  assign accept_s    = (state_r == ST_IDLE) && start;
  assign sweep_end_s = (state_r == ST_DRIVE) && last_s && (idx_r == 4'd15);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_DRIVE;
        else       state_next_s = ST_IDLE;
      end
      ST_DRIVE: begin
        if (sweep_end_s) state_next_s = ST_DONE;
        else             state_next_s = ST_DRIVE;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Vector index, dwell counter and capture of F on the last cycle of each dwell
  always_comb begin
    idx_next_s = idx_r;
    cnt_next_s = cnt_r;
    tt_next_s  = tt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          idx_next_s = 4'd0;
          cnt_next_s = 8'd0;
          tt_next_s  = 16'h0000;
        end else begin
          idx_next_s = idx_r;
        end
      end
      ST_DRIVE: begin
        if (last_s) begin
          tt_next_s[idx_r] = F;
          cnt_next_s       = 8'd0;
          if (idx_r != 4'd15) idx_next_s = idx_r + 4'd1;
          else                idx_next_s = idx_r;
        end else begin
          cnt_next_s = cnt_r + 8'd1;
        end
      end
      ST_DONE: idx_next_s = idx_r;
      default: idx_next_s = idx_r;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= 4'd0;
      cnt_r <= 8'd0;
      tt_r  <= 16'h0000;
    end else begin
      idx_r <= idx_next_s;
      cnt_r <= cnt_next_s;
      tt_r  <= tt_next_s;
    end
  end

  // Output decode, evaluated against the next state so outputs can be registered
  always_comb begin
    busy_next_s = 1'b0;
    done_next_s = 1'b0;
    vec_next_s  = 4'd0;
    case (state_next_s)
      ST_DRIVE: begin
        busy_next_s = 1'b1;
        vec_next_s  = idx_next_s;
      end
      ST_DONE: done_next_s = 1'b1;
      ST_IDLE: busy_next_s = 1'b0;
      default: busy_next_s = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_r  <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      vec_r  <= vec_next_s;
      busy_r <= busy_next_s;
      done_r <= done_next_s;
    end
  end

  assign {A, B, C, D} = vec_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign tt           = tt_r;

`ifdef TT_CHECK_EN
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  logic [4:0] err_cnt_r;
  logic       mismatch_r;
  logic [4:0] err_cnt_next_s;

  assign err_cnt_next_s = popcount16(tt_next_s ^ EXPECTED);

  // Golden comparison latched when the last vector is captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r  <= 5'd0;
      mismatch_r <= 1'b0;
    end else if (accept_s) begin
      err_cnt_r  <= 5'd0;
      mismatch_r <= 1'b0;
    end else if (sweep_end_s) begin
      err_cnt_r  <= err_cnt_next_s;
      mismatch_r <= (err_cnt_next_s != 5'd0);
    end else begin
      err_cnt_r  <= err_cnt_r;
      mismatch_r <= mismatch_r;
    end
  end

  assign err_cnt  = err_cnt_r;
  assign mismatch = mismatch_r;
`else
  logic unused_accept_s;
  assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer with DWELL=4; the monitor checks each sweep on done.
module tb_truth_table_sequencer;
  localparam int DW    = 4;
  localparam int SWEEP = 16 * DW;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        F;
  logic        A, B, C, D, busy, done;
  logic [15:0] tt;
`ifdef TT_CHECK_EN
  logic        mismatch;
  logic [4:0]  err_cnt;
`endif

  int mode     = 0;
  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  err;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  truth_table_sequencer #(.DWELL(DW), .EXPECTED(16'h6996)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .F(F),
    .A(A), .B(B), .C(C), .D(D),
    .busy(busy), .done(done), .tt(tt)
`ifdef TT_CHECK_EN
    , .mismatch(mismatch), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit under test model driven by the sequencer outputs
  always_comb begin
    F = 1'b0;
    case (mode)
      0:       F = A ^ B ^ C ^ D;
      1:       F = 1'b0;
      2:       F = 1'b1;
      default: F = A & B;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: vector stability while busy, sweep length and captured table on done
  always @(negedge clk) begin
    if (busy) begin
      check("vector", {28'd0, A, B, C, D}, busy_cnt / DW);
      busy_cnt++;
    end else if (done) begin
      check("busy_len", busy_cnt, SWEEP);
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done with empty scoreboard at cycle %0d", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("tt", {16'd0, tt}, {16'd0, mon_e.tt});
`ifdef TT_CHECK_EN
        check("err_cnt", {27'd0, err_cnt}, {27'd0, mon_e.err});
        check("mismatch", {31'd0, mismatch}, {31'd0, (mon_e.err != 5'd0)});
`endif
      end
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic push(input logic [15:0] t, input logic [4:0] e);
    exp_t x;
    x.tt  = t;
    x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
    if (d < 0) begin
      n_checks++;
      $display("FAIL done_timeout: no done within 300 cycles (cycle %0d)", cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, d1, d2, d3;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_vec", {28'd0, A, B, C, D}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tt", {16'd0, tt}, 32'd0);
`ifdef TT_CHECK_EN
    check("rst_mismatch", {31'd0, mismatch}, 32'd0);
    check("rst_err_cnt", {27'd0, err_cnt}, 32'd0);
`endif
    rst_n = 1'b1;

    // Parity unit: done 65 cycles after start, tt = 6996
    mode = 0;
    push(16'h6996, 5'd0);
    pulse_start(s);
    wait_done(d);
    check("t1_latency", d - s, 32'd65);
    repeat (3) @(negedge clk);
    check("t1_tt_hold", {16'd0, tt}, 32'h6996);

    // Constant outputs
    mode = 1;
    push(16'h0000, 5'd8);
    pulse_start(s);
    wait_done(d);
    mode = 2;
    push(16'hFFFF, 5'd8);
    pulse_start(s);
    wait_done(d);

    // F = A&B with a second start mid-sweep (ignored)
    mode = 3;
    push(16'hF000, 5'd8);
    pulse_start(s);
    repeat (57) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_mid_tt", {16'd0, tt}, 32'h3000);
    check("t3_mid_busy", {31'd0, busy}, 32'd1);
    wait_done(d);
    check("t3_latency", d - s, 32'd65);
    repeat (80) @(negedge clk);

    // Asynchronous reset during vector 5, then a clean sweep
    mode = 0;
    push(16'h6996, 5'd0);
    pulse_start(s);
    repeat (21) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_vec", {28'd0, A, B, C, D}, 32'd0);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_tt", {16'd0, tt}, 32'd0);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h6996, 5'd0);
    pulse_start(s);
    wait_done(d);
    check("t4_latency", d - s, 32'd65);

    // start held high: three back-to-back sweeps
    push(16'h6996, 5'd0);
    push(16'h6996, 5'd0);
    push(16'h6996, 5'd0);
    @(negedge clk);
    start = 1'b1;
    wait_done(d1);
    @(negedge clk);
    wait_done(d2);
    @(negedge clk);
    wait_done(d3);
    start = 1'b0;
    check("t5_gap12", d2 - d1, 32'd66);
    check("t5_gap23", d3 - d2, 32'd66);
    repeat (80) @(negedge clk);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
